vga_scene_source: RTL and testbench

- Pixel responder on the VGA controller's pixel-RAM read interface.
- Takes row/column addresses and the active-low read strobe, and returns a 12-bit bbbb_gggg_rrrr pixel one clock later.
- Renders the dinosaur game scene procedurally: background, ground band, dino rectangle and obstacle rectangle.
- Holds object positions in shadow registers. Game logic may update them only during vertical blanking, via a valid/ready handshake, so no frame tears.

---
 rtl/vga_scene_source.sv | 137 +++++++++++++
 tb/tb_vga_scene_source.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scene_source.sv
// Pixel responder for the VGA controller's pixel-RAM read port: renders the dinosaur-game scene
// procedurally and holds object positions in shadow registers that game logic may reload only in vertical blanking.
module vga_scene_source #(
    parameter int unsigned H_ACT        = 640,
    parameter int unsigned V_ACT        = 480,
    parameter int unsigned GROUND_ROW   = 400,
    parameter int unsigned DINO_X       = 64,
    parameter int unsigned DINO_W       = 20,
    parameter int unsigned DINO_H       = 24,
    parameter int unsigned OBS_W        = 12,
    parameter int unsigned OBS_H        = 20,
    parameter logic [11:0] BG_COLOR     = 12'hFFF,
    parameter logic [11:0] GROUND_COLOR = 12'h555,
    parameter logic [11:0] DINO_COLOR   = 12'h333,
    parameter logic [11:0] OBS_COLOR    = 12'h0A0
) (
    input  logic        vga_clk,
    input  logic        clr,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] pixel,
    input  logic [8:0]  dino_y,
    input  logic [9:0]  obs_x,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int unsigned ROW_W = 9;
    localparam int unsigned COL_W = 10;
    localparam int unsigned PIX_W = 12;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_VBLANK = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_frame_end;
    logic [ROW_W-1:0]   r_dino_y;
    logic [COL_W-1:0]   r_obs_x;
    logic [PIX_W-1:0]   w_pixel_nxt;
    logic [COL_W:0]     w_col_x;
    logic [COL_W:0]     w_obs_end;
    logic [ROW_W:0]     w_row_x;
    logic [ROW_W:0]     w_dino_end;
    logic               w_obs_hit;
    logic               w_dino_hit;
    logic               w_gnd_hit;

    // State register
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            r_state <= ST_VBLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame tracking: the last active pixel of the frame closes it; any active pixel opens the next
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        upd_ready   = 1'b0;
        case (r_state)
            ST_VBLANK: begin
                upd_ready = rdn;
                if (!rdn) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!rdn && (row_addr == ROW_W'(V_ACT - 1)) && (col_addr == COL_W'(H_ACT - 1))) begin
                    w_state_nxt = ST_VBLANK;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = ST_VBLANK;
        endcase
    end

    // Hit tests on widened sums so objects near the right/bottom edge clip instead of wrapping
    always_comb begin
        w_col_x    = {1'b0, col_addr};
        w_row_x    = {1'b0, row_addr};
        w_obs_end  = {1'b0, r_obs_x} + (COL_W + 1)'(OBS_W);
        w_dino_end = {1'b0, r_dino_y} + (ROW_W + 1)'(DINO_H);

        w_obs_hit  = (r_obs_x < COL_W'(H_ACT))
                   && (col_addr >= r_obs_x) && (w_col_x < w_obs_end)
                   && (row_addr >= ROW_W'(GROUND_ROW - OBS_H))
                   && (row_addr < ROW_W'(GROUND_ROW));

        w_dino_hit = (col_addr >= COL_W'(DINO_X))
                   && (w_col_x < (COL_W + 1)'(DINO_X + DINO_W))
                   && (row_addr >= r_dino_y) && (w_row_x < w_dino_end);

        w_gnd_hit  = (row_addr == ROW_W'(GROUND_ROW)) || (row_addr == ROW_W'(GROUND_ROW + 1));

        w_pixel_nxt = BG_COLOR;
        if (rdn) begin
            w_pixel_nxt = '0;
        end else if (w_obs_hit) begin
            w_pixel_nxt = OBS_COLOR;
        end else if (w_dino_hit) begin
            w_pixel_nxt = DINO_COLOR;
        end else if (w_gnd_hit) begin
            w_pixel_nxt = GROUND_COLOR;
        end
    end

    // Registered outputs and shadow position registers
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            pixel      <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            r_dino_y   <= ROW_W'(GROUND_ROW - DINO_H);
            r_obs_x    <= COL_W'(H_ACT);
        end else begin
            pixel      <= w_pixel_nxt;
            frame_tick <= w_frame_end;
            if (w_frame_end) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (upd_valid && upd_ready) begin
                r_dino_y <= dino_y;
                r_obs_x  <= obs_x;
            end
        end
    end

endmodule

// File: tb/tb_vga_scene_source.sv
// Directed bench for vga_scene_source: a scene model predicts pixel/frame/handshake outputs every cycle,
// with literal probes pinning specific scene points.
module tb_vga_scene_source;

    logic        vga_clk = 1'b0;
    logic        clr;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] pixel;
    logic [8:0]  dino_y;
    logic [9:0]  obs_x;
    logic        upd_valid;
    logic        upd_ready;
    logic        frame_tick;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit          m_known  = 1'b0;
    bit          m_active = 1'b0;
    int          m_dy     = 376;
    int          m_ox     = 640;
    logic [15:0] m_cnt    = 16'h0;

    int p_dy = 0;
    int p_ox = 0;

    int rows [18] = '{0, 99, 100, 101, 123, 124, 200, 250, 375, 376, 379, 380, 390, 399, 400, 401, 402, 479};

    vga_scene_source dut (
        .vga_clk   (vga_clk),
        .clr       (clr),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .rdn       (rdn),
        .pixel     (pixel),
        .dino_y    (dino_y),
        .obs_x     (obs_x),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .frame_tick(frame_tick),
        .frame_cnt (frame_cnt)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scene colour straight from the drawing rules, in unbounded integer arithmetic
    function automatic logic [11:0] scene(input int r, input int c, input int dy, input int ox);
        if (ox < 640 && c >= ox && c < ox + 12 && r >= 380 && r < 400) return 12'h0A0;
        if (c >= 64 && c < 84 && r >= dy && r < dy + 24) return 12'h333;
        if (r == 400 || r == 401) return 12'h555;
        return 12'hFFF;
    endfunction

    // One pixel-clock cycle: apply inputs, predict, cross the edge, compare
    task automatic step(input logic i_rdn, input int r, input int c);
        logic [11:0] e_pix;
        logic        e_tick;
        rdn      = i_rdn;
        row_addr = 9'(r);
        col_addr = 10'(c);
        #1;
        if (m_known && !clr) chk("upd_ready", 32'(upd_ready), 32'(!m_active && i_rdn));
        e_tick = 1'b0;
        if (clr) begin
            e_pix    = 12'h000;
            m_cnt    = 16'h0;
            m_active = 1'b0;
            m_dy     = 376;
            m_ox     = 640;
        end else begin
            e_pix = i_rdn ? 12'h000 : scene(r, c, m_dy, m_ox);
            if (!i_rdn) begin
                if (m_active && r == 479 && c == 639) begin
                    e_tick   = 1'b1;
                    m_cnt    = m_cnt + 16'd1;
                    m_active = 1'b0;
                end else begin
                    m_active = 1'b1;
                end
            end else if (!m_active && upd_valid) begin
                m_dy = int'(dino_y);
                m_ox = int'(obs_x);
            end
        end
        @(posedge vga_clk);
        #1;
        chk("pixel", 32'(pixel), 32'(e_pix));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        m_known = 1'b1;
    endtask

    task automatic probe(input int r, input int c, input logic [11:0] exp, input string name);
        step(1'b0, r, c);
        chk(name, 32'(pixel), 32'(exp));
    endtask

    task automatic vblank(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 480, k);
    endtask

    // Compressed frame: selected rows, each scanning three column windows, last pixel (479,639)
    task automatic run_frame(input int upd_row, input int clr_row);
        for (int i = 0; i < 18; i++) begin
            if (rows[i] == upd_row) begin
                upd_valid = 1'b1;
                dino_y    = 9'(p_dy);
                obs_x     = 10'(p_ox);
            end
            if (rows[i] == clr_row) clr = 1'b1;
            for (int c = 0; c < 100; c++) step(1'b0, rows[i], c);
            for (int c = 290; c < 340; c++) step(1'b0, rows[i], c);
            for (int c = 620; c < 640; c++) step(1'b0, rows[i], c);
            if (rows[i] != 479) begin
                for (int k = 0; k < 4; k++) step(1'b1, rows[i], 640 + k);
            end
        end
    endtask

    task automatic load(input int dy, input int ox, input string name);
        upd_valid = 1'b1;
        dino_y    = 9'(dy);
        obs_x     = 10'(ox);
        #1;
        chk(name, 32'(upd_ready), 32'd1);
        step(1'b1, 480, 0);
        upd_valid = 1'b0;
        vblank(2);
    endtask

    initial begin
        clr       = 1'b1;
        rdn       = 1'b1;
        row_addr  = '0;
        col_addr  = '0;
        upd_valid = 1'b0;
        dino_y    = '0;
        obs_x     = '0;
        vblank(3);
        clr = 1'b0;
        chk("reset_pixel", 32'(pixel), 32'h0);
        chk("reset_cnt", 32'(frame_cnt), 32'h0);
        chk("reset_tick", 32'(frame_tick), 32'h0);
        chk("reset_ready", 32'(upd_ready), 32'h1);

        // Default scene
        probe(0, 0, 12'hFFF, "a_bg_origin");
        probe(400, 10, 12'h555, "a_ground400");
        probe(401, 600, 12'h555, "a_ground401");
        probe(376, 64, 12'h333, "a_dino_tl");
        probe(399, 83, 12'h333, "a_dino_br");
        probe(399, 84, 12'hFFF, "a_dino_right");
        probe(375, 64, 12'hFFF, "a_dino_above");
        step(1'b1, 10, 10);
        chk("a_rdn_high", 32'(pixel), 32'h0);
        run_frame(-1, -1);
        chk("a_tick", 32'(frame_tick), 32'h1);
        chk("a_cnt", 32'(frame_cnt), 32'h1);
        vblank(4);

        // Moved dino and obstacle
        load(100, 300, "b_ready");
        probe(100, 70, 12'h333, "b_dino");
        probe(390, 305, 12'h0A0, "b_obs");
        probe(390, 312, 12'hFFF, "b_obs_right");
        probe(99, 70, 12'hFFF, "b_dino_above");
        probe(123, 83, 12'h333, "b_dino_br");
        probe(124, 70, 12'hFFF, "b_dino_below");
        run_frame(-1, -1);
        vblank(4);

        // Overlap: obstacle wins
        load(376, 70, "c_ready");
        probe(390, 75, 12'h0A0, "c_overlap");
        probe(390, 65, 12'h333, "c_dino_left");
        probe(390, 82, 12'h333, "c_dino_past_obs");
        run_frame(-1, -1);
        vblank(4);

        // Update requested mid-frame waits for blanking
        p_dy = 150;
        p_ox = 500;
        run_frame(200, -1);
        chk("d_cnt", 32'(frame_cnt), 32'h4);
        step(1'b1, 480, 0);
        upd_valid = 1'b0;
        vblank(2);
        probe(150, 70, 12'h333, "d_dino");
        probe(390, 505, 12'h0A0, "d_obs");
        probe(390, 75, 12'hFFF, "d_old_obs_gone");
        run_frame(-1, -1);
        vblank(4);

        // Right-edge clipping
        load(376, 635, "e_ready");
        probe(390, 635, 12'h0A0, "e_obs_left");
        probe(380, 639, 12'h0A0, "e_obs_edge");
        probe(379, 635, 12'hFFF, "e_obs_above");
        probe(390, 3, 12'hFFF, "e_no_wrap");
        probe(400, 637, 12'h555, "e_ground");
        run_frame(-1, -1);
        vblank(4);

        // Off-screen obstacle
        load(376, 700, "f_ready");
        probe(390, 639, 12'hFFF, "f_hidden");
        probe(390, 70, 12'h333, "f_dino");
        run_frame(-1, -1);
        vblank(4);

        // Frame counter wrap
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        m_cnt = 16'hFFFE;
        chk("w_preset", 32'(frame_cnt), 32'hFFFE);
        step(1'b0, 0, 0);
        step(1'b0, 479, 639);
        chk("w_cnt_ffff", 32'(frame_cnt), 32'hFFFF);
        step(1'b1, 480, 0);
        step(1'b0, 0, 0);
        step(1'b0, 479, 639);
        chk("w_cnt_wrap", 32'(frame_cnt), 32'h0);
        chk("w_tick", 32'(frame_tick), 32'h1);
        vblank(4);

        // Reset asserted mid-frame at row 250
        run_frame(-1, 250);
        chk("g_pixel", 32'(pixel), 32'h0);
        chk("g_cnt", 32'(frame_cnt), 32'h0);
        vblank(2);
        clr = 1'b0;
        step(1'b1, 480, 0);
        chk("g_ready", 32'(upd_ready), 32'h1);
        chk("g_tick", 32'(frame_tick), 32'h0);
        probe(390, 630, 12'hFFF, "g_obs_hidden");
        probe(380, 70, 12'h333, "g_dino_reset");
        run_frame(-1, -1);
        chk("g_tick_end", 32'(frame_tick), 32'h1);
        chk("g_cnt_end", 32'(frame_cnt), 32'h1);
        vblank(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
